// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the CPU data-bus responder: store codes, FSM states
// and the latched request record.
package data_bus_responder_pkg;

    // CPU store func3 encodings; the bus store strobe is func3 + 1 so 00 means "no store".
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [1:0] BUS_NONE = 2'b00;
    localparam logic [1:0] BUS_SB   = 2'b01;
    localparam logic [1:0] BUS_SH   = 2'b10;
    localparam logic [1:0] BUS_SW   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } resp_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  we;
        logic        re;
    } bus_req_t;

    function automatic logic [1:0] bus_code_from_f3(input logic [2:0] f3);
        logic [1:0] code;
        code = BUS_NONE;
        case (f3)
            F3_SB:   code = BUS_SB;
            F3_SH:   code = BUS_SH;
            F3_SW:   code = BUS_SW;
            default: code = BUS_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// CPU data bus between the multicycle core (master) and the memory responder (slave).
interface data_bus_responder_if;

    // Handshake: a request (we != 00 or re) is taken only while the responder is idle;
    // ready pulses for exactly one cycle to close it, with rdata and err valid in that
    // same cycle. A request still present during the ready cycle is not consumed.
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  we;
    logic        re;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output addr, wdata, we, re,
        input  rdata, ready, err
    );

    modport slave (
        input  addr, wdata, we, re,
        output rdata, ready, err
    );

endinterface

// File: rtl/data_bus_responder_lane_align.sv
// Store lane placement: turns a store code, byte offset and unshifted data into byte
// strobes, a lane-replicated write word and a misalignment flag.
module data_bus_responder_lane_align
    import data_bus_responder_pkg::*;
(
    input  logic [1:0]  we,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    output logic [3:0]  strobe,
    output logic [31:0] wword,
    output logic        misalign
);

    // Data is replicated into every lane so the strobes alone pick the destination.
    always_comb begin
        strobe   = 4'b0000;
        wword    = 32'h0000_0000;
        misalign = 1'b0;
        case (we)
            BUS_SB: begin
                strobe = 4'b0001 << lane;
                wword  = {4{wdata[7:0]}};
            end
            BUS_SH: begin
                strobe   = lane[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                misalign = lane[0];
            end
            BUS_SW: begin
                strobe   = 4'b1111;
                wword    = wdata;
                misalign = (lane != 2'b00);
            end
            default: begin
                strobe   = 4'b0000;
                wword    = 32'h0000_0000;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/data_bus_responder.sv
// Memory-side end of the CPU data bus: word RAM with byte strobes, programmable wait
// states and error flagging for misaligned or out-of-window accesses.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    data_bus_responder_if.slave  bus,
    output resp_state_e          dbg_state
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    resp_state_e      state;
    resp_state_e      state_nx;
    bus_req_t         req;
    logic [3:0]       wait_cnt;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic [31:0]      mem [DEPTH];

    logic             accept;
    logic             commit;
    logic             is_store;
    logic             is_load;
    logic             in_window;
    logic             bad;
    logic [IDX_W-1:0] idx;
    logic [3:0]       strobe;
    logic [31:0]      wword;
    logic             misalign;

    data_bus_responder_lane_align u_lane_align (
        .we       (req.we),
        .lane     (req.addr[1:0]),
        .wdata    (req.wdata),
        .strobe   (strobe),
        .wword    (wword),
        .misalign (misalign)
    );

    assign accept = (state == ST_IDLE) && ((bus.we != BUS_NONE) || bus.re);
    // The last ACCESS cycle is the single point where RAM is written or read.
    assign commit = (state == ST_ACCESS) && (wait_cnt == 4'd0);

    assign is_store  = (req.we != BUS_NONE);
    assign is_load   = req.re && !is_store;
    assign in_window = ({1'b0, req.addr} >= WIN_LO) && ({1'b0, req.addr} < WIN_HI);
    assign idx       = IDX_W'((req.addr - BASE_ADDR) >> 2);
    assign bad       = !in_window || (is_store && misalign);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wait_cnt == 4'd0) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req      <= '0;
            wait_cnt <= 4'd0;
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                req <= '{addr: bus.addr, wdata: bus.wdata, we: bus.we, re: bus.re};
                wait_cnt <= WAIT_INIT;
            end else if ((state == ST_ACCESS) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (commit) begin
                err_q <= bad;
                if (is_load && in_window) begin
                    rdata_q <= mem[idx];
                end else begin
                    rdata_q <= 32'h0000_0000;
                end
            end
        end
    end

    // No reset on the array: contents survive reset and are undefined after power-up.
    always_ff @(posedge clk) begin
        if (commit && is_store && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) begin
                    mem[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    assign bus.ready = (state == ST_RESP);
    assign bus.err   = (state == ST_RESP) && err_q;
    assign bus.rdata = rdata_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: three instances with different wait states, directed
// scenarios plus randomized traffic checked against a byte-level memory model.
module tb_data_bus_responder;
    import data_bus_responder_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          NDUT  = 3;

    logic        clk;
    logic        reset;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_we;
    logic        d_re;
    int          sel;

    logic [31:0] obs_rdata;
    logic        obs_ready;
    logic        obs_err;
    logic [1:0]  obs_state;

    resp_state_e st0, st1, st2;

    int n_checks;
    int n_pass;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;
    logic [31:0] model_mem [NDUT][DEPTH];

    data_bus_responder_if bus0 ();
    data_bus_responder_if bus1 ();
    data_bus_responder_if bus2 ();

    assign bus0.addr  = d_addr;
    assign bus0.wdata = d_wdata;
    assign bus0.we    = (sel == 0) ? d_we : 2'b00;
    assign bus0.re    = (sel == 0) && d_re;
    assign bus1.addr  = d_addr;
    assign bus1.wdata = d_wdata;
    assign bus1.we    = (sel == 1) ? d_we : 2'b00;
    assign bus1.re    = (sel == 1) && d_re;
    assign bus2.addr  = d_addr;
    assign bus2.wdata = d_wdata;
    assign bus2.we    = (sel == 2) ? d_we : 2'b00;
    assign bus2.re    = (sel == 2) && d_re;

    data_bus_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .dbg_state(st0));
    data_bus_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .dbg_state(st1));
    data_bus_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave), .dbg_state(st2));

    always_comb begin
        obs_rdata = bus0.rdata;
        obs_ready = bus0.ready;
        obs_err   = bus0.err;
        obs_state = st0;
        case (sel)
            1: begin
                obs_rdata = bus1.rdata; obs_ready = bus1.ready;
                obs_err = bus1.err; obs_state = st1;
            end
            2: begin
                obs_rdata = bus2.rdata; obs_ready = bus2.ready;
                obs_err = bus2.err; obs_state = st2;
            end
            default: ;
        endcase
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (dut %0d)", tag, got, exp, sel);
        end
    endtask

    function automatic int wait_of(input int s);
        return (s == 1) ? 3 : (s == 2) ? 2 : 0;
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
    endfunction

    // Reference model: applies a store byte by byte; returns the expected error flag.
    function automatic bit model_store(input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] w);
        int i;
        int off;
        bit hit;
        logic [7:0] byt;
        if (!in_win(a)) return 1'b1;
        if (w == 2'b10 && a[0]) return 1'b1;
        if (w == 2'b11 && a[1:0] != 2'b00) return 1'b1;
        i = int'((a - BASE) / 4);
        off = int'(a[1:0]);
        for (int b = 0; b < 4; b++) begin
            case (w)
                2'b01:   begin hit = (b == off);         byt = d[7:0]; end
                2'b10:   begin hit = ((b / 2) == (off / 2)); byt = d[8*(b%2) +: 8]; end
                default: begin hit = 1'b1;               byt = d[8*b +: 8]; end
            endcase
            if (hit) model_mem[sel][i][8*b +: 8] = byt;
        end
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready(output int n);
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (obs_ready || n >= 40) break;
        end
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                       input logic r, input string tag);
        bit   exp_err;
        bit   is_store;
        int   lat;
        logic [31:0] exp_rd;
        is_store = (w != 2'b00);
        if (is_store) begin
            exp_err = model_store(a, d, w);
        end else begin
            exp_err = !in_win(a);
            exp_q.push_back(in_win(a) ? model_mem[sel][int'((a - BASE) / 4)] : 32'h0);
        end
        @(negedge clk);
        d_addr = a; d_wdata = d; d_we = w; d_re = r;
        @(posedge clk); #1;
        d_we = 2'b00; d_re = 1'b0;
        lat = 1;
        if (!obs_ready) begin
            wait_ready(lat);
            lat++;
        end
        check($sformatf("%s latency", tag), 32'(lat), 32'(2 + wait_of(sel)));
        check($sformatf("%s err", tag), {31'd0, obs_err}, {31'd0, exp_err});
        if (!is_store) begin
            exp_rd = exp_q.pop_front();
            last_rd = obs_rdata;
            check($sformatf("%s rdata", tag), obs_rdata, exp_rd);
        end
        @(posedge clk); #1;
        check($sformatf("%s ready pulse", tag), {31'd0, obs_ready}, 32'd0);
    endtask

    task automatic held_test();
        int lat;
        int gap;
        bit exp_err;
        exp_err = model_store(BASE, 32'h1234_5678, 2'b11);
        @(negedge clk);
        d_addr = BASE; d_wdata = 32'h1234_5678; d_we = 2'b11; d_re = 1'b1;
        wait_ready(lat);
        check("held first latency", 32'(lat), 32'(2 + wait_of(sel)));
        check("held err", {31'd0, obs_err}, {31'd0, exp_err});
        wait_ready(gap);
        check("held reservice gap", 32'(gap), 32'(3 + wait_of(sel)));
        d_we = 2'b00; d_re = 1'b0;
        @(posedge clk); #1;
        check("held ready pulse", {31'd0, obs_ready}, 32'd0);
        txn(BASE, 32'h0, 2'b00, 1'b1, "held reload");
    endtask

    task automatic reset_abort_test();
        @(negedge clk);
        d_addr = BASE + 32'hC; d_wdata = 32'hFFFF_FFFF; d_we = 2'b11; d_re = 1'b0;
        @(posedge clk); #1;
        d_we = 2'b00;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort state", {30'd0, obs_state}, {30'd0, ST_IDLE});
        check("abort ready", {31'd0, obs_ready}, 32'd0);
        check("abort err", {31'd0, obs_err}, 32'd0);
        check("abort rdata", obs_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        txn(BASE + 32'hC, 32'h0, 2'b00, 1'b1, "abort reload");
    endtask

    task automatic random_txn(input int k);
        logic [31:0] a;
        logic [1:0]  w;
        logic        r;
        case ($urandom_range(0, 9))
            0:       a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
            1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
            default: a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
        endcase
        w = 2'($urandom_range(0, 3));
        r = (w == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
        txn(a, $urandom, w, r, $sformatf("rand%0d", k));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        sel = 0;
        d_addr = '0; d_wdata = '0; d_we = 2'b00; d_re = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < NDUT; s++) begin
            sel = s;
            #1;
            check("reset state", {30'd0, obs_state}, {30'd0, ST_IDLE});
            check("reset ready", {31'd0, obs_ready}, 32'd0);
            check("reset err", {31'd0, obs_err}, 32'd0);
            check("reset rdata", obs_rdata, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int s = 0; s < NDUT; s++) begin
            sel = s;
            for (int i = 0; i < DEPTH; i++) begin
                txn(BASE + 32'(4 * i), $urandom | 32'h1, 2'b11, 1'b0, "preload");
            end
        end

        for (int s = 0; s < 2; s++) begin
            sel = s;
            txn(BASE + 32'h8, 32'hA1B2_C3D4, 2'b11, 1'b0, "sw word");
            txn(BASE + 32'h8, 32'h0, 2'b00, 1'b1, "lw word");
            check("lw word const", last_rd, 32'hA1B2_C3D4);
            txn(BASE + 32'h9, 32'hFFFF_FF55, 2'b01, 1'b0, "sb lane1");
            txn(BASE + 32'hA, 32'hFFFF_BEEF, 2'b10, 1'b0, "sh upper");
            txn(BASE + 32'h8, 32'h0, 2'b00, 1'b1, "lw merged");
            check("lw merged const", last_rd, 32'hBEEF_55D4);
            txn(BASE + 32'h1, 32'h0000_CAFE, 2'b10, 1'b0, "sh misaligned");
            txn(BASE + 32'h6, 32'hDEAD_BEEF, 2'b11, 1'b0, "sw misaligned");
            txn(BASE + 32'h0, 32'h0, 2'b00, 1'b1, "reload w0");
            txn(BASE + 32'h4, 32'h0, 2'b00, 1'b1, "reload w1");
            txn(BASE - 32'h4, 32'h0, 2'b00, 1'b1, "lw below");
            txn(BASE + 32'(4 * DEPTH), 32'h0, 2'b00, 1'b1, "lw above");
            txn(BASE - 32'h4, 32'h5A5A_5A5A, 2'b11, 1'b0, "sw below");
            txn(BASE + 32'(4 * DEPTH), 32'hA5A5_A5A5, 2'b11, 1'b0, "sw above");
            txn(BASE + 32'h0, 32'h0, 2'b00, 1'b1, "reload first");
            txn(BASE + 32'(4 * (DEPTH - 1)), 32'h0, 2'b00, 1'b1, "reload last");
        end

        sel = 0;
        held_test();

        sel = 2;
        txn(BASE + 32'hC, 32'h0, 2'b00, 1'b1, "pre abort load");
        reset_abort_test();

        for (int s = 0; s < NDUT; s++) begin
            sel = s;
            for (int k = 0; k < 40; k++) begin
                random_txn(k);
            end
            for (int i = 0; i < DEPTH; i++) begin
                txn(BASE + 32'(4 * i), 32'h0, 2'b00, 1'b1, "final sweep");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
